i2c_slave_receiver: RTL and testbench
=====================================

// Module: i2c_slave_receiver
// PURPOSE
// I2C/PMBus target (responder) for write transactions. It lets the fabric receive the same
// address/command/data byte streams our i2c_master_fsm-based init blocks send.
// Filters SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs and presents each byte on a
// strobe. Sits at the pad pair alongside the master path, open-drain on SDA; reads are NACKed.
// PARAMETERS
// SLAVE_ADDR  7'h40  7-bit target address compared against first byte[7:1]
// FILT_LEN    3      consecutive equal synchronized samples required to accept SCL/SDA change (>=1)
// PORTS
// clock        in     1  system clock, >= 20x SCL rate
// reset        in     1  asynchronous, active-low reset
// scl          in     1  I2C clock from bus (never driven)
// sda          inout  1  I2C data; driven only 1'b0 or 1'bz
// ack_enable   in     1  1: ACK data bytes; 0: NACK data bytes (address ACK unaffected)
// rx_data      out    8  last received data byte, MSB first on wire
// rx_valid     out    1  one-clock pulse, rx_data valid
// rx_first     out    1  qualifies rx_valid: byte is first after address (PMBus command code)
// rx_start     out    1  one-clock pulse on START or repeated START
// rx_stop      out    1  one-clock pulse on STOP
// addressed    out    1  high from matching address ACK until STOP/next START
// reading_sda  out    1  1 when SDA is released (input), 0 when block pulls SDA low
// BEHAVIOUR
// - Reset (async, active-low): state IDLE, all outputs 0 except reading_sda=1; rx_data=8'h00;
//   filters preset to 1 (bus idle).
// - Input path: 2-FF synchronizer, then filter; filtered value changes only after FILT_LEN equal samples.
// - Edges: previous filtered value kept. SCL rise/fall = edge of filtered SCL.
//   START = filtered SDA 1->0 while SCL=1. STOP = SDA 0->1 while SCL=1.
// - START/STOP take priority over state logic in the same cycle. Honoured in any state.
//   START -> ADDR, bit cnt=0, addressed=0, rx_start pulse.
//   STOP -> IDLE, release SDA, addressed=0, rx_stop pulse. No partial byte is emitted.
// - Bits are shifted into an 8-bit shift reg on SCL rise; 3-bit counter, wraps 7->0.
// - FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
//   IDLE: wait START.
//   ADDR: on 8th rise compare shift[7:1] to SLAVE_ADDR.
//     Match with R/W=0 -> ADDR_ACK.
//     Mismatch or R/W=1 -> IGNORE (no drive).
//   ADDR_ACK: on next SCL fall drive SDA=0. On the following fall release SDA,
//     set addressed=1, set first-flag=1, go to DATA.
//   DATA: on 8th rise: rx_data<=shift, rx_valid=1 on the next clock, rx_first=first-flag,
//     then clear first-flag. Go to DATA_ACK.
//   DATA_ACK: if ack_enable (sampled at 8th rise) drive SDA=0 from the next fall to the following
//     fall, else leave SDA released. Then go to DATA.
//     On a NACKed byte, stay in DATA; the master decides STOP or restart.
//   IGNORE: never drive; wait START/STOP.
// - SDA drive is changed only on a filtered SCL fall (or STOP/START/reset release), never while SCL high.
// - sda = reading_sda ? 1'bz : 1'b0. Block never drives 1.
// - rx_valid, rx_start, rx_stop are exactly one clock wide; rx_first is 0 whenever rx_valid=0.
// - Latency: rx_valid is 1 clock after the filtered SCL rise of the byte's LSB, which is
//   FILT_LEN+3 clocks after the pad edge.
// - Repeated START mid-byte: shift/count discarded, new address phase. Glitch shorter than
//   FILT_LEN clocks on either line: ignored entirely.
// TESTING
// 1 Write 0x80(addr 0x40,W),0x21,0x0A,STOP, ack_enable=1 -> ACK x3; rx_valid x2:
//   0x21 with rx_first=1, 0x0A with rx_first=0; rx_start, rx_stop one pulse each.
// 2 Address 0x41 W, then bytes 0x55 -> SDA never driven, no rx_valid, addressed stays 0.
// 3 Address 0x40 with R/W=1 -> NACK (SDA released in ACK slot), state IGNORE until STOP.
// 4 Cmd 0x01, repeated START mid-second-byte (after 4 bits), new addr 0x40 W, byte 0x02 ->
//   rx_data 0x01 then 0x02 (rx_first=1 both), two rx_start pulses, no spurious byte.
// 5 ack_enable=0 during data byte 0x33 -> address ACKed, data slot released, rx_valid still
//   pulses with 0x33.
// 6 Drop reset (to 0) while the block drives ACK low -> reading_sda=1 immediately (async),
//   outputs 0; 1-clock SDA glitch with FILT_LEN=3 -> no START detected.

Source files
------------

// File: rtl/i2c_slave_receiver.sv
// ---------------------------------------------------------------------------
// i2c_slave_receiver
//
// I2C/PMBus write-only target. Both bus lines are synchronized and
// deglitched. START and STOP are detected on the filtered lines, and the first
// byte is matched against a 7-bit address. Matching address bytes and data
// bytes are ACKed by pulling SDA low in the ninth clock slot. Every data byte
// is presented on a one-clock strobe. Reads are never acknowledged.
//
// Ports
//   clk          system clock (>= 20x SCL rate)
//   rst_n        asynchronous active-low reset
//   scl          bus clock, input only
//   sda          bus data, open drain: driven 0 or released (z)
//   ack_enable   1: ACK data bytes, 0: NACK data bytes (address ACK unaffected)
//   rx_data      last received data byte
//   rx_valid     one-clock strobe, rx_data valid
//   rx_first     with rx_valid: byte is the first after the address (command)
//   rx_start     one-clock strobe on START / repeated START
//   rx_stop      one-clock strobe on STOP
//   addressed    high from the address ACK until STOP or the next START
//   reading_sda  1 = SDA released, 0 = block pulls SDA low
// ---------------------------------------------------------------------------
module i2c_slave_receiver #(
    parameter logic [6:0] SLAVE_ADDR = 7'h40,
    parameter int         FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic       ack_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       rx_start,
    output logic       rx_stop,
    output logic       addressed,
    output logic       reading_sda
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    // Open-drain output: never drive a 1.
    assign sda = reading_sda ? 1'bz : 1'b0;

    // Index 0 = SCL, index 1 = SDA.
    logic [1:0] line_raw;
    logic [1:0] line_filt;
    logic [1:0] line_prev_reg;

    assign line_raw = {sda, scl};

    // Per-line 2-FF synchronizer followed by a run-length filter: the
    // filtered value flips only after FILT_LEN consecutive differing samples;
    // any sample equal to the current value restarts the run.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic          sync1_reg;
            logic          sync2_reg;
            logic          filt_reg;
            logic [CW-1:0] run_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    run_reg   <= '0;
                end else begin
                    sync1_reg <= line_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        run_reg <= '0;
                    end else if (run_reg == CW'(FILT_LEN - 1)) begin
                        filt_reg <= sync2_reg;
                        run_reg  <= '0;
                    end else begin
                        run_reg <= run_reg + 1'b1;
                    end
                end
            end

            assign line_filt[gi] = filt_reg;
        end
    endgenerate

    logic scl_f, sda_f;
    logic scl_rise, scl_fall;
    logic start_det, stop_det;

    assign scl_f     = line_filt[0];
    assign sda_f     = line_filt[1];
    assign scl_rise  =  scl_f & ~line_prev_reg[0];
    assign scl_fall  = ~scl_f &  line_prev_reg[0];
    assign start_det =  scl_f &  line_prev_reg[1] & ~sda_f;
    assign stop_det  =  scl_f & ~line_prev_reg[1] &  sda_f;

    state_t     state_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       ack_phase_reg;  // 0: waiting for the fall that opens the ACK slot
    logic       ack_drive_reg;  // ack_enable captured with the data byte
    logic       first_reg;

    logic [7:0] byte_in;
    assign byte_in = {shift_reg[6:0], sda_f};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_prev_reg <= 2'b11;
            state_reg     <= IDLE;
            shift_reg     <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            ack_phase_reg <= 1'b0;
            ack_drive_reg <= 1'b0;
            first_reg     <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_first      <= 1'b0;
            rx_start      <= 1'b0;
            rx_stop       <= 1'b0;
            addressed     <= 1'b0;
            reading_sda   <= 1'b1;
        end else begin
            line_prev_reg <= line_filt;
            rx_valid      <= 1'b0;
            rx_first      <= 1'b0;
            rx_start      <= 1'b0;
            rx_stop       <= 1'b0;

            // Bus conditions override whatever the byte machine is doing;
            // a partially shifted byte is simply abandoned.
            if (start_det) begin
                state_reg     <= ADDR;
                bit_cnt_reg   <= 3'd0;
                ack_phase_reg <= 1'b0;
                addressed     <= 1'b0;
                reading_sda   <= 1'b1;
                rx_start      <= 1'b1;
            end else if (stop_det) begin
                state_reg     <= IDLE;
                bit_cnt_reg   <= 3'd0;
                ack_phase_reg <= 1'b0;
                addressed     <= 1'b0;
                reading_sda   <= 1'b1;
                rx_stop       <= 1'b1;
            end else begin
                case (state_reg)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= byte_in;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                if (byte_in[7:1] == SLAVE_ADDR && !byte_in[0])
                                    state_reg <= ADDR_ACK;
                                else
                                    state_reg <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        // First fall opens the ACK slot, second fall closes it.
                        if (scl_fall) begin
                            if (!ack_phase_reg) begin
                                ack_phase_reg <= 1'b1;
                                reading_sda   <= 1'b0;
                            end else begin
                                ack_phase_reg <= 1'b0;
                                reading_sda   <= 1'b1;
                                addressed     <= 1'b1;
                                first_reg     <= 1'b1;
                                state_reg     <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift_reg   <= byte_in;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                rx_data       <= byte_in;
                                rx_valid      <= 1'b1;
                                rx_first      <= first_reg;
                                first_reg     <= 1'b0;
                                ack_drive_reg <= ack_enable;
                                state_reg     <= DATA_ACK;
                            end
                        end
                    end
                    DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_reg) begin
                                ack_phase_reg <= 1'b1;
                                reading_sda   <= ~ack_drive_reg;
                            end else begin
                                ack_phase_reg <= 1'b0;
                                reading_sda   <= 1'b1;
                                state_reg     <= DATA;
                            end
                        end
                    end
                    default: ;  // IDLE and IGNORE only react to START/STOP
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_receiver
//
// Directed bench: a bit-banged bus master drives SCL/SDA through an
// open-drain bus with pull-up. A negedge monitor records received bytes and
// strobe counts. Each scenario task compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_i2c_slave_receiver;

    localparam int H = 20;  // clocks per SCL half period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic       ack_enable = 1'b1;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, rx_start, rx_stop, addressed, reading_sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_receiver #(.SLAVE_ADDR(7'h40), .FILT_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
        .ack_enable(ack_enable), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_first(rx_first), .rx_start(rx_start), .rx_stop(rx_stop),
        .addressed(addressed), .reading_sda(reading_sda)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [7:0] rx_q[$];
    logic       first_q[$];
    int         start_cnt = 0, stop_cnt = 0, drive_cyc = 0, pulse_err = 0;
    int         valid_cyc = 0;
    bit         addr_seen = 1'b0;
    logic       pv = 1'b0, ps = 1'b0, pp = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && !pv) begin
                rx_q.push_back(rx_data);
                first_q.push_back(rx_first);
                valid_cyc = cyc;
                $display("rx byte 0x%02h first=%0b", rx_data, rx_first);
            end
            if (rx_valid && pv) pulse_err++;
            if (rx_first && !rx_valid) pulse_err++;
            if (rx_start && !ps) start_cnt++;
            if (rx_start && ps) pulse_err++;
            if (rx_stop && !pp) stop_cnt++;
            if (rx_stop && pp) pulse_err++;
            if (!reading_sda) drive_cyc++;
            if (addressed) addr_seen = 1'b1;
        end
        pv = rx_valid;
        ps = rx_start;
        pp = rx_stop;
    end

    // ---------------- bus master ----------------
    int lsb_rise_cyc = 0;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        wait_n(H); m_low = 1'b1; wait_n(H); scl = 1'b0;
    endtask

    task automatic bus_restart();
        wait_n(H / 2); m_low = 1'b0; wait_n(H / 2); scl = 1'b1;
        wait_n(H); m_low = 1'b1; wait_n(H); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_n(H / 2); m_low = 1'b1; wait_n(H / 2); scl = 1'b1;
        wait_n(H); m_low = 1'b0; wait_n(H);
    endtask

    task automatic send_bit(input logic b);
        wait_n(H / 2); m_low = !b; wait_n(H / 2);
        scl = 1'b1; lsb_rise_cyc = cyc;
        wait_n(H); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_n(H / 2); m_low = 1'b0; wait_n(H / 2); scl = 1'b1;
        wait_n(H / 2); acked = (sda === 1'b0);
        wait_n(H / 2); scl = 1'b0;
        $display("sent byte 0x%02h acked=%0b", b, acked);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wait_n(4);
        checks++; if (reading_sda !== 1'b1) begin errors++; $display("FAIL reset_reading_sda: got %0b expected 1", reading_sda); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
        checks++; if ({rx_valid, rx_first, rx_start, rx_stop, addressed} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", {rx_valid, rx_first, rx_start, rx_stop, addressed}); end
        rst_n = 1'b1;
        wait_n(10);
    endtask

    task automatic test_basic_write();
        logic a0, a1, a2;
        int   base = rx_q.size();
        int   s0 = start_cnt, p0 = stop_cnt;
        int   lat;
        ack_enable = 1'b1;
        bus_start();
        send_byte(8'h80, a0);
        send_byte(8'h21, a1);
        lat = valid_cyc - lsb_rise_cyc;
        send_byte(8'h0A, a2);
        checks++; if (addressed !== 1'b1) begin errors++; $display("FAIL basic_addressed: got %0b expected 1", addressed); end
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL basic_acks: got %b expected 111", {a0, a1, a2}); end
        checks++; if (rx_q.size() - base != 2) begin errors++; $display("FAIL basic_count: got %0d expected 2", rx_q.size() - base); end
        if (rx_q.size() - base >= 2) begin
            checks++; if (rx_q[base] !== 8'h21 || first_q[base] !== 1'b1) begin
                errors++; $display("FAIL basic_byte0: got %0h/%0b expected 21/1", rx_q[base], first_q[base]); end
            checks++; if (rx_q[base+1] !== 8'h0A || first_q[base+1] !== 1'b0) begin
                errors++; $display("FAIL basic_byte1: got %0h/%0b expected 0a/0", rx_q[base+1], first_q[base+1]); end
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6", lat); end
        checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
            errors++; $display("FAIL basic_start_stop: got %0d/%0d expected 1/1", start_cnt - s0, stop_cnt - p0); end
        checks++; if (addressed !== 1'b0) begin errors++; $display("FAIL basic_addr_after_stop: got %0b expected 0", addressed); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int   base = rx_q.size();
        int   d0 = drive_cyc;
        addr_seen = 1'b0;
        bus_start();
        send_byte(8'h82, a0);
        send_byte(8'h55, a1);
        bus_stop();
        checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL wrong_addr_acks: got %b expected 00", {a0, a1}); end
        checks++; if (drive_cyc != d0) begin errors++; $display("FAIL wrong_addr_drive: got %0d expected 0", drive_cyc - d0); end
        checks++; if (rx_q.size() != base) begin errors++; $display("FAIL wrong_addr_rx: got %0d expected 0", rx_q.size() - base); end
        checks++; if (addr_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_addressed: got %0b expected 0", addr_seen); end
    endtask

    task automatic test_read_nack();
        logic a0, a1;
        int   base = rx_q.size();
        int   d0 = drive_cyc, p0 = stop_cnt;
        bus_start();
        send_byte(8'h81, a0);
        send_byte(8'h5A, a1);
        checks++; if (dut.state_reg !== 3'd5) begin errors++; $display("FAIL read_state: got %0d expected 5", dut.state_reg); end
        bus_stop();
        checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL read_acks: got %b expected 00", {a0, a1}); end
        checks++; if (drive_cyc != d0 || rx_q.size() != base) begin
            errors++; $display("FAIL read_quiet: got drive=%0d rx=%0d expected 0/0", drive_cyc - d0, rx_q.size() - base); end
        checks++; if (stop_cnt - p0 != 1) begin errors++; $display("FAIL read_stop: got %0d expected 1", stop_cnt - p0); end
    endtask

    task automatic test_restart();
        logic a0, a1, a2, a3;
        int   base = rx_q.size();
        int   s0 = start_cnt;
        bus_start();
        send_byte(8'h80, a0);
        send_byte(8'h01, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_restart();
        send_byte(8'h80, a2);
        send_byte(8'h02, a3);
        bus_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL restart_acks: got %b expected 1111", {a0, a1, a2, a3}); end
        checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL restart_starts: got %0d expected 2", start_cnt - s0); end
        checks++; if (rx_q.size() - base != 2) begin errors++; $display("FAIL restart_count: got %0d expected 2", rx_q.size() - base); end
        if (rx_q.size() - base >= 2) begin
            checks++; if ({rx_q[base], first_q[base], rx_q[base+1], first_q[base+1]} !== {8'h01, 1'b1, 8'h02, 1'b1}) begin
                errors++; $display("FAIL restart_bytes: got %0h/%0b %0h/%0b expected 01/1 02/1",
                                   rx_q[base], first_q[base], rx_q[base+1], first_q[base+1]); end
        end
    endtask

    task automatic test_nack_data();
        logic a0, a1;
        int   base = rx_q.size();
        ack_enable = 1'b0;
        bus_start();
        send_byte(8'h80, a0);
        send_byte(8'h33, a1);
        bus_stop();
        ack_enable = 1'b1;
        checks++; if ({a0, a1} !== 2'b10) begin errors++; $display("FAIL nack_acks: got %b expected 10", {a0, a1}); end
        checks++; if (rx_q.size() - base != 1) begin errors++; $display("FAIL nack_count: got %0d expected 1", rx_q.size() - base); end
        if (rx_q.size() - base >= 1) begin
            checks++; if (rx_q[base] !== 8'h33 || first_q[base] !== 1'b1) begin
                errors++; $display("FAIL nack_byte: got %0h/%0b expected 33/1", rx_q[base], first_q[base]); end
        end
    endtask

    task automatic test_async_reset_glitch();
        int s0;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7);
        wait_n(H / 2); m_low = 1'b0; wait_n(H / 2); scl = 1'b1; wait_n(H / 2);
        checks++; if (reading_sda !== 1'b0) begin errors++; $display("FAIL ack_drive_before_reset: got %0b expected 0", reading_sda); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (reading_sda !== 1'b1 || sda !== 1'b1) begin
            errors++; $display("FAIL async_release: got %0b/%0b expected 1/1", reading_sda, sda); end
        checks++; if ({rx_data, rx_valid, rx_start, rx_stop, addressed} !== 12'h000) begin
            errors++; $display("FAIL async_outputs: got %0h expected 000", {rx_data, rx_valid, rx_start, rx_stop, addressed}); end
        wait_n(3);
        rst_n = 1'b1;
        wait_n(10);
        s0 = start_cnt;
        m_low = 1'b1; wait_n(1); m_low = 1'b0; wait_n(10);
        m_low = 1'b1; wait_n(2); m_low = 1'b0; wait_n(20);
        checks++; if (start_cnt != s0) begin errors++; $display("FAIL glitch_start: got %0d expected 0", start_cnt - s0); end
        bus_start();
        bus_stop();
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL real_start_after_glitch: got %0d expected 1", start_cnt - s0); end
    endtask

    task automatic test_pulse_widths();
        checks++; if (pulse_err != 0) begin errors++; $display("FAIL pulse_width: got %0d violations expected 0", pulse_err); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrong_addr();
        test_read_nack();
        test_restart();
        test_nack_data();
        test_async_reset_glitch();
        test_pulse_widths();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
